// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner issuing one imem request at a time, with a one-word
// hold buffer for downstream stalls and redirect flush/drain of stale responses
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic         hold_valid_q, hold_valid_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         consumed;
  logic         req_outstanding;

  assign consumed = out_valid_q && !stall;

  // A request stays in flight past this edge if one is pending and its
  // response is not arriving now, or if REQ is being accepted right now.
  assign req_outstanding = ((state_q == WAIT)  && !imem_resp_valid) ||
                           ((state_q == REQ)   &&  imem_req_ready)  ||
                           ((state_q == DRAIN) && !imem_resp_valid);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    if (consumed) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
      out_pc_d    = '0;
    end

    if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      out_pc_d     = '0;
      hold_valid_d = 1'b0;
      hold_instr_d = NOP_INSTR;
      hold_pc_d    = '0;
      state_d      = req_outstanding ? DRAIN : REQ;
    end else begin
      case (state_q)
        REQ: begin
          if (imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            pc_d = pc_q + INSTR_BYTES;
            if (!out_valid_q || consumed) begin
              out_valid_d = 1'b1;
              out_instr_d = imem_resp_data;
              out_pc_d    = pc_q;
              state_d     = REQ;
            end else begin
              hold_valid_d = 1'b1;
              hold_instr_d = imem_resp_data;
              hold_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (consumed && hold_valid_q) begin
            out_valid_d  = 1'b1;
            out_instr_d  = hold_instr_q;
            out_pc_d     = hold_pc_q;
            hold_valid_d = 1'b0;
            hold_instr_d = NOP_INSTR;
            hold_pc_d    = '0;
            state_d      = REQ;
          end
        end
        DRAIN: begin
          if (imem_resp_valid) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;

  assign f_valid = out_valid_q;
  assign f_instr = out_instr_q;
  assign f_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage with a
// latency-randomizing memory and an in-order instruction-stream reference
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;

  int checks = 0;
  int errors = 0;

  // memory behaviour knobs
  int ready_pct = 100;
  int lat_min   = 1;
  int lat_max   = 1;

  // memory state: one outstanding word, counted down to its response cycle
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          mem_stale;

  // reference: next PC the decode side should receive, next PC to be requested
  logic [31:0] exp_pc;
  logic [31:0] req_exp;
  bit          hold_exp;
  int          cyc;
  int          idle;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .f_valid         (f_valid),
    .f_instr         (f_instr),
    .f_pc            (f_pc)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    mem_pend  = 1'b0;
    mem_stale = 1'b0;
    mem_cnt   = 0;
    exp_pc    = RST_PC;
    req_exp   = RST_PC;
    hold_exp  = 1'b0;
    idle      = 0;
  endtask

  // one clock cycle: memory drives its side, edge, then reference update and checks
  task automatic cycle();
    bit          fv, st, rd, del, acc, stale_del;
    logic [31:0] fp, fi, ra, rt;
    del             = mem_pend && (mem_cnt == 1);
    imem_resp_valid = del;
    imem_resp_data  = del ? (mem_addr ^ KEY) : $urandom;
    imem_req_ready  = ($urandom_range(0, 99) < ready_pct);
    fv  = f_valid;
    fp  = f_pc;
    fi  = f_instr;
    st  = stall;
    rd  = redirect_valid;
    rt  = {redirect_pc[31:2], 2'b00};
    acc = imem_req_valid && imem_req_ready;
    ra  = imem_req_addr;
    stale_del = mem_stale;
    @(posedge clock);
    #1;
    cyc++;
    idle++;

    if (del) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (acc) begin
      check("one_outstanding", 32'(mem_pend), 32'd0);
      check("req_addr", ra, req_exp);
      req_exp   = req_exp + 32'd4;
      mem_pend  = 1'b1;
      mem_cnt   = $urandom_range(lat_min, lat_max);
      mem_addr  = ra;
      mem_stale = 1'b0;
    end

    if (rd) begin
      exp_pc    = rt;
      req_exp   = rt;
      mem_stale = mem_pend;
      hold_exp  = 1'b0;
      idle      = 0;
      check("redirect_clears", 32'(f_valid), 32'd0);
    end else begin
      if (fv && !st) begin
        exp_pc = exp_pc + 32'd4;
        idle   = 0;
      end
      if (del && !stale_del) begin
        check("resp_lands", 32'(f_valid), 32'd1);
        if (fv && st) begin
          hold_exp = 1'b1;
          check("hold_no_req", 32'(imem_req_valid), 32'd0);
        end else begin
          check("next_req", 32'(imem_req_valid), 32'd1);
        end
      end else if (hold_exp && fv && !st) begin
        hold_exp = 1'b0;
        check("hold_to_out", 32'(f_valid), 32'd1);
        check("req_after_hold", 32'(imem_req_valid), 32'd1);
      end else if (hold_exp) begin
        check("hold_no_req", 32'(imem_req_valid), 32'd0);
      end
      if (st && fv) begin
        check("stall_hold_pc", f_pc, fp);
        check("stall_hold_instr", f_instr, fi);
      end
    end

    if (f_valid) begin
      check("f_pc", f_pc, exp_pc);
      check("f_instr", f_instr, exp_pc ^ KEY);
    end else begin
      check("bubble_instr", f_instr, 32'd0);
      check("bubble_pc", f_pc, 32'd0);
    end
    if (!imem_req_valid) check("idle_addr", imem_req_addr, 32'd0);
    if (idle > 80) begin
      check("progress", 32'd0, 32'd1);
      idle = 0;
    end
  endtask

  task automatic run_until_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cycle();
      if (f_valid) ok = 1'b1;
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int last;
    cyc = 0;

    // reset state and k=1 stream
    do_reset();
    check("rst_f_valid", 32'(f_valid), 32'd0);
    check("rst_f_pc", f_pc, 32'd0);
    check("rst_f_instr", f_instr, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_req_addr", imem_req_addr, RST_PC);
    last = 0;
    for (int j = 0; j < 3; j++) begin
      run_until_valid(10, ok);
      check("stream_pc", f_pc, RST_PC + 32'(4 * j));
      check("stream_instr", f_instr, (RST_PC + 32'(4 * j)) ^ KEY);
      if (j > 0) check("stream_spacing", 32'(cyc - last), 32'd2);
      last = cyc;
    end

    // stall with hold
    do_reset();
    run_until_valid(10, ok);
    run_until_valid(10, ok);
    check("pre_stall_pc", f_pc, 32'h104);
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("stall_pc_104", f_pc, 32'h104);
      if (i >= 1) check("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    stall = 1'b0;
    cycle();
    check("release_valid", 32'(f_valid), 32'd1);
    check("release_pc", f_pc, 32'h108);
    check("release_req", 32'(imem_req_valid), 32'd1);
    check("release_addr", imem_req_addr, 32'h10C);

    // redirect while WAIT with a late response
    lat_min = 3;
    lat_max = 3;
    do_reset();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2003;
    cycle();
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (imem_req_valid) ok = 1'b1;
      else begin
        check("drain_no_valid", 32'(f_valid), 32'd0);
        cycle();
      end
    end
    check("drain_req_seen", 32'(ok), 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h2000);
    run_until_valid(20, ok);
    check("redir_first_pc", f_pc, 32'h2000);

    // redirect + stall + simultaneous response
    lat_min = 1;
    lat_max = 1;
    do_reset();
    run_until_valid(10, ok);
    stall = 1'b1;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    cycle();
    redirect_valid = 1'b0;
    stall = 1'b0;
    check("rs_f_valid", 32'(f_valid), 32'd0);
    check("rs_f_pc", f_pc, 32'd0);
    check("rs_f_instr", f_instr, 32'd0);
    check("rs_req_valid", 32'(imem_req_valid), 32'd1);
    check("rs_req_addr", imem_req_addr, 32'h3000);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    run_until_valid(10, ok);
    check("wrap_pc_hi", f_pc, 32'hFFFF_FFFC);
    run_until_valid(10, ok);
    check("wrap_pc_lo", f_pc, 32'h0000_0000);

    // async reset while HOLD
    do_reset();
    run_until_valid(10, ok);
    stall = 1'b1;
    repeat (3) cycle();
    check("hold_pre_reset", 32'(f_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("arst_f_valid", 32'(f_valid), 32'd0);
    check("arst_f_instr", f_instr, 32'd0);
    check("arst_f_pc", f_pc, 32'd0);
    do_reset();
    check("arst_req_valid", 32'(imem_req_valid), 32'd1);
    check("arst_req_addr", imem_req_addr, RST_PC);

    // randomized traffic
    ready_pct = 70;
    lat_min   = 1;
    lat_max   = 4;
    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
